wb_port_scheduler: RTL and testbench



---
 rtl/wb_port_scheduler.sv | 170 +++++++++++++++++
 tb/tb_wb_port_scheduler.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/wb_port_scheduler.sv
// Y86-64 write-back scheduler: serializes dstE/dstM onto one register-file port and owns the RUN/HALTED status.
// Optional perf counters (retired_cnt, wb_stall_cnt) are built only when WB_PERF_EN is defined.
module wb_port_scheduler (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  W_stat,
  input  logic [3:0]  W_icode,
  input  logic [63:0] W_valE,
  input  logic [63:0] W_valM,
  input  logic [3:0]  W_dstE,
  input  logic [3:0]  W_dstM,
  output logic        rf_we,
  output logic [3:0]  rf_dst,
  output logic [63:0] rf_data,
  output logic        wb_stall,
  output logic [1:0]  cpu_stat,
  output logic        halted,
  output logic [63:0] retired_cnt,
  output logic [31:0] wb_stall_cnt
);

  localparam logic [3:0] RNONE     = 4'hF;
  localparam logic [3:0] NOP_ICODE = 4'h1;
  localparam logic [1:0] STAT_AOK  = 2'b00;

  typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} stat_state_e;
  typedef enum logic {PORT_FIRST = 1'b0, PORT_SECOND = 1'b1} port_state_e;

  stat_state_e stat_q, stat_d;
  port_state_e port_q, port_d;
  logic [1:0]  cpu_stat_q, cpu_stat_d;
  logic        dste_vld_s, dstm_vld_s, live_s, retire_s;

  assign dste_vld_s = (W_dstE != RNONE);
  assign dstm_vld_s = (W_dstM != RNONE);
  assign live_s     = (W_stat == STAT_AOK);

  // Next-state for both FSMs and the combinational write-port drive
  always_comb begin
    stat_d     = stat_q;
    port_d     = port_q;
    cpu_stat_d = cpu_stat_q;
    rf_we      = 1'b0;
    rf_dst     = RNONE;
    rf_data    = 64'd0;
    wb_stall   = 1'b0;
    if (rst_n) begin
      case (stat_q)
        ST_RUN: begin
          if (!live_s) begin
            stat_d     = ST_HALTED;
            cpu_stat_d = W_stat;
          end else begin
            stat_d     = ST_RUN;
          end
          case (port_q)
            PORT_SECOND: begin
              // W is held, so the M half still completes even on a late fault
              rf_we   = 1'b1;
              rf_dst  = W_dstM;
              rf_data = W_valM;
              port_d  = PORT_FIRST;
            end
            PORT_FIRST: begin
              if (!live_s) begin
                port_d = PORT_FIRST;
              end else if (dste_vld_s && dstm_vld_s) begin
                if (W_dstE == W_dstM) begin
                  rf_we   = 1'b1;
                  rf_dst  = W_dstM;
                  rf_data = W_valM;
                end else begin
                  rf_we    = 1'b1;
                  rf_dst   = W_dstE;
                  rf_data  = W_valE;
                  wb_stall = 1'b1;
                  port_d   = PORT_SECOND;
                end
              end else if (dste_vld_s) begin
                rf_we   = 1'b1;
                rf_dst  = W_dstE;
                rf_data = W_valE;
              end else if (dstm_vld_s) begin
                rf_we   = 1'b1;
                rf_dst  = W_dstM;
                rf_data = W_valM;
              end else begin
                rf_we   = 1'b0;
              end
            end
            default: port_d = PORT_FIRST;
          endcase
        end
        ST_HALTED: begin
          stat_d = ST_HALTED;
          port_d = PORT_FIRST;
        end
        default: begin
          stat_d = ST_HALTED;
          port_d = PORT_FIRST;
        end
      endcase
    end else begin
      rf_we    = 1'b0;
      rf_dst   = RNONE;
      rf_data  = 64'd0;
      wb_stall = 1'b0;
    end
  end

  // Status and port state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stat_q     <= ST_RUN;
      port_q     <= PORT_FIRST;
      cpu_stat_q <= 2'b00;
    end else begin
      stat_q     <= stat_d;
      port_q     <= port_d;
      cpu_stat_q <= cpu_stat_d;
    end
  end

  assign cpu_stat = cpu_stat_q;
  assign halted   = (stat_q == ST_HALTED);

  // Final write-back cycle of a live, non-bubble instruction
  assign retire_s = (stat_q == ST_RUN) && live_s && (W_icode != NOP_ICODE) && !wb_stall && rst_n;

`ifdef WB_PERF_EN
  logic [63:0] retired_cnt_q, retired_cnt_d;
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Counter next-state: retirement wraps, stall count saturates
  always_comb begin
    retired_cnt_d = retired_cnt_q;
    stall_cnt_d   = stall_cnt_q;
    if (retire_s) begin
      retired_cnt_d = retired_cnt_q + 64'd1;
    end else begin
      retired_cnt_d = retired_cnt_q;
    end
    if (wb_stall && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      retired_cnt_q <= 64'd0;
      stall_cnt_q   <= 32'd0;
    end else begin
      retired_cnt_q <= retired_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
    end
  end

  assign retired_cnt  = retired_cnt_q;
  assign wb_stall_cnt = stall_cnt_q;
`else
  logic unused_perf_s;
  assign unused_perf_s = retire_s;
  assign retired_cnt   = 64'd0;
  assign wb_stall_cnt  = 32'd0;
`endif

endmodule

// File: tb/tb_wb_port_scheduler.sv
// Directed bench for wb_port_scheduler; counter expectations follow WB_PERF_EN.
module tb_wb_port_scheduler;

`ifdef WB_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clk;
  logic        rst_n;
  logic [1:0]  W_stat;
  logic [3:0]  W_icode;
  logic [63:0] W_valE;
  logic [63:0] W_valM;
  logic [3:0]  W_dstE;
  logic [3:0]  W_dstM;
  logic        rf_we;
  logic [3:0]  rf_dst;
  logic [63:0] rf_data;
  logic        wb_stall;
  logic [1:0]  cpu_stat;
  logic        halted;
  logic [63:0] retired_cnt;
  logic [31:0] wb_stall_cnt;

  int n_tests = 0;
  int n_fail  = 0;

  wb_port_scheduler dut (
    .clk(clk), .rst_n(rst_n),
    .W_stat(W_stat), .W_icode(W_icode), .W_valE(W_valE), .W_valM(W_valM),
    .W_dstE(W_dstE), .W_dstM(W_dstM),
    .rf_we(rf_we), .rf_dst(rf_dst), .rf_data(rf_data), .wb_stall(wb_stall),
    .cpu_stat(cpu_stat), .halted(halted),
    .retired_cnt(retired_cnt), .wb_stall_cnt(wb_stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive(input logic [1:0] st, input logic [3:0] ic, input logic [3:0] de,
                       input logic [3:0] dm, input logic [63:0] ve, input logic [63:0] vm);
    W_stat  = st;
    W_icode = ic;
    W_dstE  = de;
    W_dstM  = dm;
    W_valE  = ve;
    W_valM  = vm;
  endtask

  task automatic expect_wb(input string tag, input logic we, input logic [3:0] dst,
                           input logic [63:0] data, input logic stall);
    check_eq({tag, ".we"},    {63'd0, rf_we},    {63'd0, we});
    check_eq({tag, ".dst"},   {60'd0, rf_dst},   {60'd0, dst});
    check_eq({tag, ".data"},  rf_data,           data);
    check_eq({tag, ".stall"}, {63'd0, wb_stall}, {63'd0, stall});
  endtask

  task automatic expect_st(input string tag, input logic h, input logic [1:0] cs,
                           input logic [63:0] ret, input logic [31:0] stc);
    check_eq({tag, ".halted"},   {63'd0, halted},       {63'd0, h});
    check_eq({tag, ".cpu_stat"}, {62'd0, cpu_stat},     {62'd0, cs});
    check_eq({tag, ".retired"},  retired_cnt,           PERF ? ret : 64'd0);
    check_eq({tag, ".stallcnt"}, {32'd0, wb_stall_cnt}, PERF ? {32'd0, stc} : 64'd0);
  endtask

  initial begin
    rst_n = 1'b0;
    drive(2'b00, 4'h3, 4'h3, 4'hF, 64'h55, 64'h0);
    #2;
    expect_wb("reset", 1'b0, 4'hF, 64'h0, 1'b0);
    expect_st("reset", 1'b0, 2'b00, 64'd0, 32'd0);

    @(negedge clk); rst_n = 1'b1; #1;
    expect_wb("irmovq", 1'b1, 4'h3, 64'h55, 1'b0);

    @(negedge clk); drive(2'b00, 4'hB, 4'h4, 4'h0, 64'h108, 64'hAB); #1;
    expect_wb("popq_c1", 1'b1, 4'h4, 64'h108, 1'b1);
    @(negedge clk); #1;
    expect_wb("popq_c2", 1'b1, 4'h0, 64'hAB, 1'b0);

    @(negedge clk); drive(2'b00, 4'hB, 4'h4, 4'h4, 64'h108, 64'h77); #1;
    expect_wb("popq_rsp", 1'b1, 4'h4, 64'h77, 1'b0);
    expect_st("after_popq", 1'b0, 2'b00, 64'd2, 32'd1);

    @(negedge clk); drive(2'b00, 4'h5, 4'hF, 4'h1, 64'h0, 64'h99); #1;
    expect_wb("mrmovq", 1'b1, 4'h1, 64'h99, 1'b0);

    for (int i = 0; i < 3; i++) begin
      @(negedge clk); drive(2'b00, 4'h1, 4'hF, 4'hF, 64'h0, 64'h0); #1;
      expect_wb("nop", 1'b0, 4'hF, 64'h0, 1'b0);
    end
    expect_st("before_irm", 1'b0, 2'b00, 64'd4, 32'd1);
    for (int i = 0; i < 2; i++) begin
      @(negedge clk); drive(2'b00, 4'h3, 4'(5 + i), 4'hF, 64'(16 + i), 64'h0); #1;
      expect_wb("irm_stream", 1'b1, 4'(5 + i), 64'(16 + i), 1'b0);
    end

    @(negedge clk); drive(2'b00, 4'hB, 4'h4, 4'h0, 64'h108, 64'hAB); #1;
    expect_st("after_stream", 1'b0, 2'b00, 64'd6, 32'd1);
    expect_wb("popq2_c1", 1'b1, 4'h4, 64'h108, 1'b1);
    @(negedge clk); #1;
    expect_wb("popq2_c2", 1'b1, 4'h0, 64'hAB, 1'b0);
    rst_n = 1'b0; #1;
    expect_wb("rst_mid", 1'b0, 4'hF, 64'h0, 1'b0);
    expect_st("rst_mid", 1'b0, 2'b00, 64'd0, 32'd0);

    @(negedge clk); rst_n = 1'b1; drive(2'b00, 4'h3, 4'h7, 4'hF, 64'h1234, 64'h0); #1;
    expect_wb("irm_after_rst", 1'b1, 4'h7, 64'h1234, 1'b0);

    @(negedge clk); drive(2'b01, 4'h0, 4'h2, 4'hF, 64'hDEAD, 64'h0); #1;
    expect_wb("hlt", 1'b0, 4'hF, 64'h0, 1'b0);
    check_eq("hlt.halted_pre", {63'd0, halted}, 64'd0);

    @(negedge clk); drive(2'b00, 4'h3, 4'h3, 4'hF, 64'h55, 64'h0); #1;
    expect_wb("post_hlt", 1'b0, 4'hF, 64'h0, 1'b0);
    expect_st("post_hlt", 1'b1, 2'b01, 64'd1, 32'd0);

    @(negedge clk); drive(2'b00, 4'hB, 4'h4, 4'h0, 64'h108, 64'hAB); #1;
    expect_wb("halted_popq", 1'b0, 4'hF, 64'h0, 1'b0);
    expect_st("halted_popq", 1'b1, 2'b01, 64'd1, 32'd0);

    @(negedge clk); rst_n = 1'b0; #1;
    expect_st("rst_halt", 1'b0, 2'b00, 64'd0, 32'd0);
    @(negedge clk); rst_n = 1'b1; drive(2'b10, 4'h5, 4'hF, 4'h1, 64'h0, 64'h99); #1;
    expect_wb("adr", 1'b0, 4'hF, 64'h0, 1'b0);
    @(negedge clk); #1;
    expect_st("adr_latched", 1'b1, 2'b10, 64'd0, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
